gppcu_lmem_dma: RTL

Host-side initiator for the thread local-memory port A (LMEMSEL/LMEMWREN/LMEMADDR/LMEMWDATA/LMEMRDATA) shared by all GPPCU threads. It executes block-transfer commands in two directions: it streams words from a valid/ready source into one thread's local memory, or into all threads in broadcast, and it reads a thread's local memory out to a valid/ready sink. It sits between the host/command bridge and the thread array. The top level ties every thread's iLMEMCLK to iACLK.

---
 rtl/gppcu_lmem_dma.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/gppcu_lmem_dma.sv
// gppcu_lmem_dma
// Host-side block-transfer initiator for the shared thread local-memory port A.
// Write commands stream words from a valid/ready source into one thread's
// local memory, or into every thread at once (broadcast). Read commands fetch
// words from one thread's local memory through a small return FIFO that feeds
// a valid/ready sink.
//
// Ports:
//   iACLK, iRST         clock, synchronous active-high reset
//   iCMD_*/oCMD_READY   command channel (DIR, BCAST, THREAD, ADDR, LEN)
//   iWR_* / oWR_READY   write-data stream (source -> LMEM)
//   oRD_* / iRD_READY   read-data stream (LMEM -> sink)
//   oLMEM*/iLMEMRDATA   thread local-memory port A; thread k read data at [k*DBW +: DBW]
//   oBUSY, oDONE        busy level, one-cycle completion pulse
module gppcu_lmem_dma #(
    parameter int NUM_THREADS   = 8,
    parameter int TSEL_BITS     = 3,
    parameter int ABW           = 10,
    parameter int DBW           = 32,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                       iACLK,
    input  logic                       iRST,
    input  logic                       iCMD_VALID,
    output logic                       oCMD_READY,
    input  logic                       iCMD_DIR,
    input  logic                       iCMD_BCAST,
    input  logic [TSEL_BITS-1:0]       iCMD_THREAD,
    input  logic [ABW-1:0]             iCMD_ADDR,
    input  logic [ABW:0]               iCMD_LEN,
    input  logic [DBW-1:0]             iWR_DATA,
    input  logic                       iWR_VALID,
    output logic                       oWR_READY,
    output logic [DBW-1:0]             oRD_DATA,
    output logic                       oRD_VALID,
    input  logic                       iRD_READY,
    output logic [NUM_THREADS-1:0]     oLMEMSEL,
    output logic                       oLMEMWREN,
    output logic [ABW-1:0]             oLMEMADDR,
    output logic [DBW-1:0]             oLMEMWDATA,
    input  logic [NUM_THREADS*DBW-1:0] iLMEMRDATA,
    output logic                       oBUSY,
    output logic                       oDONE
);

    localparam int CNTW = $clog2(RD_FIFO_DEPTH + 1);
    localparam int PTRW = $clog2(RD_FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_READ   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]             r_state;
    logic                   r_bcast;
    logic [TSEL_BITS-1:0]   r_thread;
    logic [ABW-1:0]         r_addr;
    logic [ABW:0]           r_rem;
    logic [NUM_THREADS-1:0] r_lmem_sel;
    logic                   r_lmem_wren;
    logic [ABW-1:0]         r_lmem_addr;
    logic [DBW-1:0]         r_lmem_wdata;
    // Read pipeline: p0 = address on the port this cycle, p1 = its data on
    // iLMEMRDATA this cycle (thread RAM has one cycle of read latency).
    logic                   r_iss_p0;
    logic                   r_iss_p1;

    logic [DBW-1:0]         r_fifo [RD_FIFO_DEPTH];
    logic [PTRW-1:0]        r_wptr;
    logic [PTRW-1:0]        r_rptr;
    logic [CNTW-1:0]        r_cnt;

    logic [NUM_THREADS-1:0] w_wsel;
    logic [DBW-1:0]         w_rd_word;
    logic [CNTW:0]          w_occ;
    logic                   w_wr_beat;
    logic                   w_issue;
    logic                   w_pop;
    logic                   w_rd_last;

    function automatic logic [PTRW-1:0] f_ptr_next(input logic [PTRW-1:0] p);
        return (p == PTRW'(RD_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Out-of-range thread index selects nothing: writes go nowhere, reads yield 0.
    always_comb begin
        w_wsel    = '0;
        w_rd_word = '0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            if (r_thread == TSEL_BITS'(k)) begin
                w_wsel[k] = 1'b1;
                w_rd_word = iLMEMRDATA[k*DBW +: DBW];
            end
        end
        if (r_bcast) begin
            w_wsel = '1;
        end
    end

    assign oWR_READY = (r_state == S_WRITE) && (r_rem != '0);
    assign w_wr_beat = iWR_VALID && oWR_READY;
    assign w_pop     = (r_cnt != '0) && iRD_READY;

    // Count words already buffered plus words still in the read pipeline so the
    // FIFO can never be asked to hold more than its depth.
    assign w_occ   = {1'b0, r_cnt} + {{CNTW{1'b0}}, r_iss_p0} + {{CNTW{1'b0}}, r_iss_p1};
    assign w_issue = (r_state == S_READ) && (r_rem != '0) &&
                     (w_occ < (CNTW+1)'(RD_FIFO_DEPTH));

    // Last word is leaving the FIFO (or already gone) with nothing left to issue.
    assign w_rd_last = (r_state == S_READ) && (r_rem == '0) && !r_iss_p0 && !r_iss_p1 &&
                       (r_cnt == {{(CNTW-1){1'b0}}, w_pop});

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            r_state      <= S_IDLE;
            r_bcast      <= 1'b0;
            r_thread     <= '0;
            r_addr       <= '0;
            r_rem        <= '0;
            r_lmem_sel   <= '0;
            r_lmem_wren  <= 1'b0;
            r_lmem_addr  <= '0;
            r_lmem_wdata <= '0;
            r_iss_p0     <= 1'b0;
            r_iss_p1     <= 1'b0;
        end else begin
            r_lmem_sel  <= '0;
            r_lmem_wren <= 1'b0;
            r_iss_p0    <= w_issue;
            r_iss_p1    <= r_iss_p0;
            case (r_state)
                S_IDLE: begin
                    if (iCMD_VALID) begin
                        r_bcast  <= iCMD_BCAST && !iCMD_DIR;
                        r_thread <= iCMD_THREAD;
                        r_addr   <= iCMD_ADDR;
                        r_rem    <= iCMD_LEN;
                        if (iCMD_LEN == '0)
                            r_state <= S_FINISH;
                        else if (iCMD_DIR)
                            r_state <= S_READ;
                        else
                            r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_wr_beat) begin
                        r_lmem_wren  <= 1'b1;
                        r_lmem_sel   <= w_wsel;
                        r_lmem_addr  <= r_addr;
                        r_lmem_wdata <= iWR_DATA;
                        r_addr       <= r_addr + 1'b1;
                        r_rem        <= r_rem - 1'b1;
                        if (r_rem == (ABW+1)'(1))
                            r_state <= S_FINISH;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_lmem_addr <= r_addr;
                        r_addr      <= r_addr + 1'b1;
                        r_rem       <= r_rem - 1'b1;
                    end
                    if (w_rd_last)
                        r_state <= S_FINISH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (r_iss_p1)
                r_wptr <= f_ptr_next(r_wptr);
            if (w_pop)
                r_rptr <= f_ptr_next(r_rptr);
            case ({r_iss_p1, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge iACLK) begin
        if (r_iss_p1)
            r_fifo[r_wptr] <= w_rd_word;
    end

    assign oCMD_READY = (r_state == S_IDLE);
    assign oBUSY      = (r_state != S_IDLE);
    assign oDONE      = (r_state == S_FINISH);
    assign oRD_VALID  = (r_cnt != '0);
    assign oRD_DATA   = oRD_VALID ? r_fifo[r_rptr] : '0;
    assign oLMEMSEL   = r_lmem_sel;
    assign oLMEMWREN  = r_lmem_wren;
    assign oLMEMADDR  = r_lmem_addr;
    assign oLMEMWDATA = r_lmem_wdata;

endmodule
